// File: rtl/io_ctrl_pkg.sv
// Shared memory-mapped I/O definitions: register addresses, I/O page and read fill value.
package io_ctrl_pkg;

  localparam logic [15:0] ADDR_KEYDATA = 16'hFFF0;
  localparam logic [15:0] ADDR_SWDATA  = 16'hFFF2;
  localparam logic [15:0] ADDR_KEYSTAT = 16'hFFF4;
  localparam logic [15:0] ADDR_HEX     = 16'hFFF8;
  localparam logic [15:0] ADDR_LEDR    = 16'hFFFA;
  localparam logic [15:0] ADDR_LEDG    = 16'hFFFC;

  localparam logic [15:0] DOUT_FILL    = 16'hDEAD;
  localparam logic [11:0] IO_PAGE      = 12'hFFF;

  // True when a data-memory address falls in the I/O page.
  function automatic logic io_hit(input logic [15:0] addr);
    return addr[15:4] == IO_PAGE;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer, tick-sampled history and debounced level for a bus of raw inputs.
module io_debounce #(
  parameter int unsigned      WIDTH       = 4,
  parameter int unsigned      DEB_SAMPLES = 4,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] deb_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] hist_q [DEB_SAMPLES];
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] all_hi;
  logic [WIDTH-1:0] all_lo;

  // Synchronize the asynchronous raw inputs into the clock domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
    end
  end

  // Shift the synchronized level into the history on every sample tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEB_SAMPLES; i++) begin
        hist_q[i] <= RST_VAL;
      end
    end else if (tick_i) begin
      hist_q[0] <= sync_q;
      for (int unsigned i = 1; i < DEB_SAMPLES; i++) begin
        hist_q[i] <= hist_q[i-1];
      end
    end
  end

  // A bit moves only when every history entry agrees; otherwise it holds.
  always_comb begin
    all_hi = '1;
    all_lo = '1;
    for (int unsigned i = 0; i < DEB_SAMPLES; i++) begin
      all_hi = all_hi & hist_q[i];
      all_lo = all_lo & ~hist_q[i];
    end
    deb_d = (deb_q | all_hi) & ~all_lo;
  end

  // Debounced level register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deb_q <= RST_VAL;
    end else begin
      deb_q <= deb_d;
    end
  end

  assign deb_o  = deb_q;
  // Falling edge seen one cycle early so event logic can act on the same edge as deb_q.
  assign fall_o = deb_q & ~deb_d;

endmodule

// File: rtl/io_ctrl.sv
// Memory-mapped I/O block: debounced keys/switches, key event status, HEX and LED registers.
module io_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 16'd50000,
  parameter int unsigned DEB_SAMPLES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] ADDR,
  input  logic [15:0] DIN,
  input  logic        WE,
  output logic [15:0] DOUT,
  output logic        HIT,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic [15:0] HEX,
  output logic [9:0]  LEDR,
  output logic [7:0]  LEDG
);

  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic        tick;
  logic [7:0]  keystat_q, keystat_d;
  logic [15:0] hex_q, hex_d;
  logic [9:0]  ledr_q, ledr_d;
  logic [7:0]  ledg_q, ledg_d;
  logic [3:0]  key_deb, key_fall;
  logic [9:0]  sw_deb;
  // Switches carry no event status, so their edge output is intentionally dropped.
  logic [9:0]  sw_fall_unused;

  assign tick = (tick_cnt_q == 16'(TICK_CYCLES - 1));
  assign HIT  = io_hit(ADDR);

  io_debounce #(
    .WIDTH       (4),
    .DEB_SAMPLES (DEB_SAMPLES),
    .RST_VAL     (4'hF)
  ) u_key_deb (
    .clk_i  (CLK),
    .rst_i  (RST),
    .tick_i (tick),
    .raw_i  (KEY),
    .deb_o  (key_deb),
    .fall_o (key_fall)
  );

  io_debounce #(
    .WIDTH       (10),
    .DEB_SAMPLES (DEB_SAMPLES),
    .RST_VAL     (10'h000)
  ) u_sw_deb (
    .clk_i  (CLK),
    .rst_i  (RST),
    .tick_i (tick),
    .raw_i  (SW),
    .deb_o  (sw_deb),
    .fall_o (sw_fall_unused)
  );

  // Next-state for tick counter, key status (W1C then press set) and output registers.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 16'd1;
    keystat_d  = keystat_q;
    hex_d      = hex_q;
    ledr_d     = ledr_q;
    ledg_d     = ledg_q;
    if (WE) begin
      case (ADDR)
        ADDR_KEYSTAT: keystat_d = keystat_q & ~DIN[7:0];
        ADDR_HEX:     hex_d     = DIN;
        ADDR_LEDR:    ledr_d    = DIN[9:0];
        ADDR_LEDG:    ledg_d    = DIN[7:0];
        default:      ;
      endcase
    end
    // Press applied after the clear so a simultaneous press wins.
    for (int unsigned i = 0; i < 4; i++) begin
      if (key_fall[i]) begin
        if (keystat_q[i]) begin
          keystat_d[4+i] = 1'b1;
        end
        keystat_d[i] = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_cnt_q <= '0;
      keystat_q  <= '0;
      hex_q      <= '0;
      ledr_q     <= '0;
      ledg_q     <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      keystat_q  <= keystat_d;
      hex_q      <= hex_d;
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
    end
  end

  // Load data mux; anything outside the register map reads the fill value.
  always_comb begin
    case (ADDR)
      ADDR_KEYDATA: DOUT = {12'h000, key_deb};
      ADDR_SWDATA:  DOUT = {6'h00, sw_deb};
      ADDR_KEYSTAT: DOUT = {8'h00, keystat_q};
      ADDR_HEX:     DOUT = hex_q;
      ADDR_LEDR:    DOUT = {6'h00, ledr_q};
      ADDR_LEDG:    DOUT = {8'h00, ledg_q};
      default:      DOUT = DOUT_FILL;
    endcase
  end

  assign HEX  = hex_q;
  assign LEDR = ledr_q;
  assign LEDG = ledg_q;

endmodule

// File: tb/tb_io_ctrl.sv
// Randomized self-checking bench for io_ctrl against a sample-queue reference model.
module tb_io_ctrl;

  localparam int unsigned TICK = 4;
  localparam int unsigned DEB  = 4;
  localparam logic [13:0] RST_RAW = 14'h000F;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] ADDR = '0;
  logic [15:0] DIN = '0;
  logic        WE = 1'b0;
  logic [15:0] DOUT;
  logic        HIT;
  logic [3:0]  KEY = 4'hF;
  logic [9:0]  SW = '0;
  logic [15:0] HEX;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;

  int n_checks = 0;
  int n_fail   = 0;

  io_ctrl #(
    .TICK_CYCLES (TICK),
    .DEB_SAMPLES (DEB)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .ADDR (ADDR),
    .DIN  (DIN),
    .WE   (WE),
    .DOUT (DOUT),
    .HIT  (HIT),
    .KEY  (KEY),
    .SW   (SW),
    .HEX  (HEX),
    .LEDR (LEDR),
    .LEDG (LEDG)
  );

  always #5 CLK = ~CLK;

  // Reference model: raw inputs reach the sampler two edges late; every TICK-th edge
  // after reset takes a sample; a bit takes a new level once the last DEB samples agree.
  int unsigned m_cyc;
  logic [13:0] m_raw1, m_raw2;
  logic [13:0] m_samp[$];
  logic [13:0] m_deb;
  logic [7:0]  m_stat;
  logic [15:0] m_hex;
  logic [9:0]  m_ledr;
  logic [7:0]  m_ledg;

  task automatic m_reset();
    m_cyc  = 0;
    m_raw1 = RST_RAW;
    m_raw2 = RST_RAW;
    m_samp.delete();
    repeat (DEB) m_samp.push_back(RST_RAW);
    m_deb  = RST_RAW;
    m_stat = '0;
    m_hex  = '0;
    m_ledr = '0;
    m_ledg = '0;
  endtask

  task automatic m_step();
    logic [13:0] nd;
    logic [3:0]  fell;
    logic [7:0]  ns;
    int          ones;
    nd = m_deb;
    for (int b = 0; b < 14; b++) begin
      ones = 0;
      foreach (m_samp[k]) ones += int'(m_samp[k][b]);
      if (ones == int'(DEB)) nd[b] = 1'b1;
      else if (ones == 0) nd[b] = 1'b0;
    end
    fell = m_deb[3:0] & ~nd[3:0];
    ns = m_stat;
    if (WE && ADDR == 16'hFFF4) ns = ns & ~DIN[7:0];
    for (int i = 0; i < 4; i++) begin
      if (fell[i]) begin
        if (m_stat[i]) ns[i+4] = 1'b1;
        ns[i] = 1'b1;
      end
    end
    if (WE) begin
      case (ADDR)
        16'hFFF8: m_hex  = DIN;
        16'hFFFA: m_ledr = DIN[9:0];
        16'hFFFC: m_ledg = DIN[7:0];
        default:  ;
      endcase
    end
    m_cyc++;
    if (m_cyc % TICK == 0) begin
      m_samp.push_back(m_raw2);
      void'(m_samp.pop_front());
    end
    m_raw2 = m_raw1;
    m_raw1 = {SW, KEY};
    m_deb  = nd;
    m_stat = ns;
  endtask

  always @(posedge CLK) begin
    if (RST) m_reset();
    else m_step();
  end

  function automatic logic [15:0] m_read(input logic [15:0] a);
    case (a)
      16'hFFF0: return {12'h000, m_deb[3:0]};
      16'hFFF2: return {6'h00, m_deb[13:4]};
      16'hFFF4: return {8'h00, m_stat};
      16'hFFF8: return m_hex;
      16'hFFFA: return {6'h00, m_ledr};
      16'hFFFC: return {8'h00, m_ledg};
      default:  return 16'hDEAD;
    endcase
  endfunction

  // Next edge will register a debounced press of key b.
  function automatic logic m_fall_pending(input int b);
    logic all_lo;
    all_lo = 1'b1;
    foreach (m_samp[k]) if (m_samp[k][b]) all_lo = 1'b0;
    return all_lo && m_deb[b];
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'hFFF0 + 16'($urandom_range(0, 15));
  endfunction

  // One clock: drive bus, check combinational read and outputs, then take the edge.
  task automatic cyc(input logic [15:0] a, input logic w, input logic [15:0] d);
    logic exp_hit;
    ADDR = a;
    WE   = w;
    DIN  = d;
    #1;
    exp_hit = (a[15:4] == 12'hFFF);
    chk("dout", DOUT, m_read(a));
    chk("hit", {15'h0, HIT}, {15'h0, exp_hit});
    chk("hex", HEX, m_hex);
    chk("ledr", {6'h0, LEDR}, {6'h0, m_ledr});
    chk("ledg", {8'h0, LEDG}, {8'h0, m_ledg});
    @(posedge CLK);
    #1;
    WE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(rand_addr(), 1'b0, 16'($urandom));
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    ADDR = a;
    WE   = 1'b0;
    #1;
    chk(tag, DOUT, exp);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic found;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    rd("rst_keydata", 16'hFFF0, 16'h000F);
    rd("rst_swdata", 16'hFFF2, 16'h0000);
    rd("rst_keystat", 16'hFFF4, 16'h0000);
    rd("rst_fff6", 16'hFFF6, 16'hDEAD);
    chk("rst_hex", HEX, 16'h0000);
    idle(10);

    // Clean press of KEY[1]
    KEY = 4'b1101;
    idle(19);
    rd("k1_keydata", 16'hFFF0, 16'h000D);
    rd("k1_keystat", 16'hFFF4, 16'h0002);
    idle(20);
    rd("k1_hold_keystat", 16'hFFF4, 16'h0002);
    KEY = 4'hF;
    idle(20);
    cyc(16'hFFF4, 1'b1, 16'hFFFF);
    rd("k1_cleared", 16'hFFF4, 16'h0000);

    // Bouncing KEY[2]
    for (int c = 0; c < 40; c++) begin
      KEY = (((c / 3) % 2) != 0) ? 4'b1011 : 4'hF;
      idle(1);
    end
    KEY = 4'hF;
    idle(20);
    rd("bounce_keydata", 16'hFFF0, 16'h000F);
    rd("bounce_keystat", 16'hFFF4, 16'h0000);

    // Overrun, W1C, and press-vs-clear collision on KEY[0]
    repeat (2) begin
      KEY = 4'b1110;
      idle(20);
      KEY = 4'hF;
      idle(20);
    end
    rd("ovr_keystat", 16'hFFF4, 16'h0011);
    cyc(16'hFFF4, 1'b1, 16'h0010);
    rd("w1c_keystat", 16'hFFF4, 16'h0001);
    KEY = 4'b1110;
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (m_fall_pending(0)) begin
        cyc(16'hFFF4, 1'b1, 16'h0001);
        found = 1'b1;
        break;
      end
      idle(1);
    end
    chk("collide_found", {15'h0, found}, 16'h0001);
    rd("collide_keystat", 16'hFFF4, 16'h0011);
    KEY = 4'hF;
    idle(20);
    cyc(16'hFFF4, 1'b1, 16'h00FF);

    // Output registers and ignored writes
    cyc(16'hFFF8, 1'b1, 16'h1234);
    cyc(16'hFFFA, 1'b1, 16'hFFFF);
    cyc(16'hFFFC, 1'b1, 16'hABCD);
    chk("hex_val", HEX, 16'h1234);
    chk("ledr_val", {6'h0, LEDR}, 16'h03FF);
    chk("ledg_val", {8'h0, LEDG}, 16'h00CD);
    rd("hex_rb", 16'hFFF8, 16'h1234);
    rd("ledr_rb", 16'hFFFA, 16'h03FF);
    rd("ledg_rb", 16'hFFFC, 16'h00CD);
    cyc(16'hFFF0, 1'b1, 16'h0000);
    rd("ro_keydata", 16'hFFF0, 16'h000F);
    cyc(16'hFFF6, 1'b1, 16'h5555);
    cyc(16'h0FF8, 1'b1, 16'h5555);
    chk("nohit_hex", HEX, 16'h1234);

    // Reset during a partial debounce
    SW  = 10'h2AA;
    KEY = 4'b0110;
    idle(8);
    RST = 1'b1;
    #1;
    chk("rst_async_hex", HEX, 16'h0000);
    rd("rst_mid_swdata", 16'hFFF2, 16'h0000);
    KEY = 4'hF;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    rd("post_rst_swdata", 16'hFFF2, 16'h0000);
    idle(30);
    rd("post_rst_keystat", 16'hFFF4, 16'h0000);
    rd("post_rst_swdata_settled", 16'hFFF2, 16'h02AA);

    // Randomized traffic
    for (int s = 0; s < 40; s++) begin
      KEY = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      SW  = 10'($urandom);
      for (int n = int'($urandom_range(1, 24)); n > 0; n--) begin
        if ($urandom_range(0, 3) == 0) cyc(rand_addr(), 1'b1, 16'($urandom));
        else idle(1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_ctrl.md
IO_CTRL -- requirements
Module: io_ctrl

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 16'd50000: clock cycles between debounce samples.
REQ-002 SHALL have parameter DEB_SAMPLES, default 4: number of consecutive equal samples required to accept a new input level.
REQ-003 SHALL have port CLK  input  1  the single clock, all state on posedge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ADDR  input  16  data-memory byte address from the processor's memory stage.
REQ-006 SHALL have port DIN  input  16  store data.
REQ-007 SHALL have port WE  input  1  store strobe, one cycle per store.
REQ-008 SHALL have port DOUT  output  16  load data, combinational from ADDR and registered state.
REQ-009 SHALL have port HIT  output  1  high when ADDR[15:4]==12'hFFF.
REQ-010 SHALL have port KEY  input  4  raw pushbuttons, asynchronous, active-low.
REQ-011 SHALL have port SW  input  10  raw slide switches, asynchronous.
REQ-012 SHALL have port HEX  output  16  seven-segment value, 4 hex digits.
REQ-013 SHALL have port LEDR  output  10  red LEDs.
REQ-014 SHALL have port LEDG  output  8  green LEDs.

Function
REQ-015 SHALL use this register map: FFF0 KEYDATA (RO), FFF2 SWDATA (RO), FFF4 KEYSTAT (R/W1C), FFF8 HEX (R/W), FFFA LEDR (R/W), FFFC LEDG (R/W).
REQ-016 SHALL drive DOUT=16'hDEAD for any ADDR not in REQ-015 (including FFF6, FFFE and non-HIT addresses).
REQ-017 SHALL zero-extend narrow registers on read: KEYDATA {12'b0,keys}, SWDATA {6'b0,sw}, LEDR {6'b0,ledr}, LEDG {8'b0,ledg}.
REQ-018 SHALL pass each KEY and SW bit through a 2-flop synchronizer before any other use.
REQ-019 SHALL generate a one-cycle sample tick every TICK_CYCLES clocks from a free-running counter that wraps to 0 after TICK_CYCLES-1.
REQ-020 SHALL, on each tick, shift each synchronized bit into a DEB_SAMPLES-deep history.
REQ-021 SHALL update a debounced bit only when all DEB_SAMPLES history entries agree and differ from its current value; otherwise it holds.
REQ-022 SHALL keep debounced KEY bits active-low, so KEYDATA reads 4'hF with no key pressed.
REQ-023 SHALL set KEYSTAT[i] (i=0..3) for one press event when debounced KEY[i] changes from 1 to 0; releases set nothing.
REQ-024 SHALL set KEYSTAT[4+i] (overrun) if a press event on key i occurs while KEYSTAT[i] is already 1.
REQ-025 SHALL, on a WE to FFF4, clear every KEYSTAT bit whose DIN bit is 1; KEYSTAT[15:8] read 0.
REQ-026 SHALL let a press event win over a W1C clear of the same bit in the same cycle.
REQ-027 SHALL, on a WE to FFF8/FFFA/FFFC, load HEX<=DIN, LEDR<=DIN[9:0], LEDG<=DIN[7:0] respectively, visible after that edge.
REQ-028 SHALL ignore WE to read-only, unmapped, or non-HIT addresses.
REQ-029 SHALL have press-to-KEYSTAT latency of at most 2+DEB_SAMPLES*TICK_CYCLES+1 cycles.

Reset
REQ-030 SHALL, while RST is high, force HEX=0, LEDR=0, LEDG=0, KEYSTAT=0, tick counter=0, debounced keys=4'hF, debounced switches=0, synchronizers and histories to those same levels.
REQ-031 SHALL generate no press event from the reset-to-first-sample transition. A reset mid-debounce discards the partial history.

Structure
REQ-032 SHALL place the address constants (FFF0..FFFC) and the 16'hDEAD fill value in a shared package used by the processor top.
REQ-033 SHALL implement synchronizer, history and debounced output in one parameterized sub-module io_debounce (width parameter), instantiated once for KEY (width 4) and once for SW (width 10), sharing the tick.

Verification
REQ-034 SHALL cover this scenario (TICK_CYCLES=4, DEB_SAMPLES=4): reset -> KEYDATA=0x000F, SWDATA=0, KEYSTAT=0, HEX=0, and FFF6 reads 0xDEAD.
REQ-035 SHALL cover this scenario: KEY[1] low, clean -> KEYDATA=0x000D and KEYSTAT=0x0002 within 19 cycles; holding the key sets nothing further.
REQ-036 SHALL cover this scenario: KEY[2] bouncing 1/0 every 3 cycles for 40 cycles, then stable high -> KEYDATA stays 0x000F and KEYSTAT stays 0.
REQ-037 SHALL cover this scenario: two KEY[0] presses without a clear -> KEYSTAT=0x0011; write 0x0010 to FFF4 -> 0x0001; write 0x0001 in the same cycle as a new KEY[0] press -> bit 0 stays 1 and bit 4 becomes 1.
REQ-038 SHALL cover this scenario: writes of 0x1234 to FFF8, 0xFFFF to FFFA, 0xABCD to FFFC -> HEX=0x1234, LEDR=0x3FF, LEDG=0xCD, with readback 0x1234/0x03FF/0x00CD; a write to FFF0 leaves KEYDATA unchanged.
REQ-039 SHALL cover this scenario: RST asserted mid-debounce with SW=0x2AA pending -> SWDATA=0, and no KEYSTAT bit is set after release.
